// File: rtl/md_pkg.sv
// md_pkg: shared MDOp encodings, default latencies
// and FSM state type for the multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MULT_LAT_D = 5;
  localparam int DIV_LAT_D  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational HI/LO result for MULT/MULTU/DIV/DIVU.
// Ports: a_i, b_i, op_i in; hi_o, lo_o out.
module md_calc
  import md_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic        sa;
  logic        sb;
  logic        bz;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] bu_safe;
  logic [31:0] bm_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] mq;
  logic [31:0] mr;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    sa     = a_i[31];
    sb     = b_i[31];
    bz     = (b_i == '0);
    a_mag  = sa ? -a_i : a_i;
    b_mag  = sb ? -b_i : b_i;
    prod_s = {{32{sa}}, a_i} * {{32{sb}}, b_i};
    prod_u = {32'd0, a_i} * {32'd0, b_i};
    // Keep the dividers X-free on B=0; result is overridden below.
    bu_safe = bz ? 32'd1 : b_i;
    bm_safe = bz ? 32'd1 : b_mag;
    uq = a_i / bu_safe;
    ur = a_i % bu_safe;
    // Signed divide on magnitudes: 0x80000000 / -1 falls out
    // as 0x80000000 rem 0 without any special case.
    mq = a_mag / bm_safe;
    mr = a_mag % bm_safe;
    sq = (sa ^ sb) ? -mq : mq;
    sr = sa ? -mr : mr;
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    unique case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s;
      MD_MULTU: {hi_o, lo_o} = prod_u;
      MD_DIV: begin
        hi_o = bz ? a_i : sr;
        lo_o = bz ? (sa ? 32'h0000_0001 : 32'hFFFF_FFFF) : sq;
      end
      MD_DIVU: begin
        hi_o = bz ? a_i : ur;
        lo_o = bz ? 32'hFFFF_FFFF : uq;
      end
      default: begin
        hi_o = '0;
        lo_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: fixed-latency multiply/divide with HI/LO registers.
// Ports: clk, reset(n), A, B, MDOp, start, flush -> busy, HI, LO.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        start,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = (MAXL < 2) ? 1 : $clog2(MAXL);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        go;
  logic        is_md;
  logic        is_mthi;
  logic        is_mtlo;

  md_calc u_calc (
    .a_i  (A),
    .b_i  (B),
    .op_i (MDOp),
    .hi_o (res_hi),
    .lo_o (res_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    go        = start & ~flush;
    is_md     = go & ~MDOp[2];
    is_mthi   = go & (MDOp == MD_MTHI);
    is_mtlo   = go & (MDOp == MD_MTLO);
    unique case (state_q)
      MD_IDLE: begin
        unique case (1'b1)
          is_md: begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = MDOp[1] ? CW'(DIV_LAT - 1)
                                : CW'(MULT_LAT - 1);
            state_d   = MD_RUN;
          end
          is_mthi: hi_d = A;
          is_mtlo: lo_d = A;
          default: ;
        endcase
      end
      MD_RUN: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// Drives on negedge, samples on negedge.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  MDOp = '0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clk = ~clk;

  md_unit #(
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .start (start),
    .flush (flush),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'd0: return sa * sbv;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0)
          return {a, a[31] ? 32'h1 : 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {hi_m, lo_m};
    endcase
  endfunction

  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] res,
                        input int flush_at,
                        input bit repulse);
    exp_t e;
    exp_t g;
    int   cycles;
    @(negedge clk);
    start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    e.res = (flush_at > 0) ? {hi_m, lo_m} : res;
    e.lat = (flush_at > 0) ? flush_at : (op[1] ? 10 : 5);
    sb.push_back(e);
    cycles = 0;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    while (busy && cycles < 100) begin
      cycles++;
      start = repulse && (cycles == 3);
      if (start) MDOp = MD_MULT;
      flush = (cycles == flush_at);
      @(negedge clk);
    end
    start = 1'b0;
    flush = 1'b0;
    g = sb.pop_front();
    chk({tag, " busy cycles"}, 64'(cycles), 64'(g.lat));
    chk({tag, " hi:lo"}, {HI, LO}, g.res);
    hi_m = g.res[63:32];
    lo_m = g.res[31:0];
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi:lo", {HI, LO}, 64'd0);
    reset = 1'b1;

    // preload HI/LO, then reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; MDOp = MD_MTHI; A = 32'hAAAA_5555;
    @(negedge clk);
    MDOp = MD_MTLO; A = 32'h5555_AAAA;
    @(negedge clk);
    chk("preload hi:lo", {HI, LO}, 64'hAAAA_5555_5555_AAAA);
    MDOp = MD_DIV; A = 32'd100; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("div running", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst hi:lo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("no late commit busy", 64'(busy), 64'd0);
    chk("no late commit", {HI, LO}, 64'd0);
    hi_m = '0;
    lo_m = '0;

    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3,
           64'hFFFF_FFFF_FFFF_FFFA, 0, 1'b0);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3,
           64'h0000_0002_FFFF_FFFA, 0, 1'b0);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
    run_op("divu b0", MD_DIVU, 32'd7, 32'd0,
           64'h0000_0007_FFFF_FFFF, 0, 1'b0);
    run_op("div b0 neg", MD_DIV, 32'h8000_0005, 32'd0,
           64'h8000_0005_0000_0001, 0, 1'b0);
    run_op("div b0 pos", MD_DIV, 32'h0000_0009, 32'd0,
           64'h0000_0009_FFFF_FFFF, 0, 1'b0);
    run_op("div ovf repulse", MD_DIV, 32'h8000_0000,
           32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 1'b1);

    // back-to-back MTHI then MTLO
    @(negedge clk);
    start = 1'b1; MDOp = MD_MTHI; A = 32'h1234_5678;
    @(negedge clk);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi hi:lo", {HI, LO}, {32'h1234_5678, lo_m});
    MDOp = MD_MTLO; A = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo busy", 64'(busy), 64'd0);
    chk("mtlo hi:lo", {HI, LO}, 64'h1234_5678_9ABC_DEF0);
    hi_m = 32'h1234_5678;
    lo_m = 32'h9ABC_DEF0;

    run_op("flush run", MD_MULT, 32'd1234, 32'd5678,
           64'd0, 3, 1'b0);

    // flush beats start, MULT and MTHI alike
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    MDOp = MD_MULT; A = 32'd5; B = 32'd7;
    @(negedge clk);
    chk("flush+mult busy", 64'(busy), 64'd0);
    MDOp = MD_MTHI; A = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush+mthi busy", 64'(busy), 64'd0);
    chk("flush+start hi:lo", {HI, LO}, {hi_m, lo_m});

    // MDOp 6/7 are no-ops
    @(negedge clk);
    start = 1'b1; MDOp = 3'd6; A = 32'hCAFE_0001;
    @(negedge clk);
    MDOp = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("nop busy", 64'(busy), 64'd0);
    chk("nop hi:lo", {HI, LO}, {hi_m, lo_m});

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 4) ? 32'd0 : $urandom;
      if (i == 6) rb = 32'hFFFF_FFFF;
      run_op("random", rop, ra, rb, model(rop, ra, rb), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide responder that sits beside the combinational ALU in the EX stage of the MIPS pipeline.
- The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with a one-cycle start pulse. The unit holds busy for the fixed latency, then commits the results to the HI/LO registers.
- The hazard unit stalls on busy. MFHI/MFLO read HI/LO directly.

Parameters:
- MULT_LAT, 5, cycles from the start edge to the HI/LO commit for MULT/MULTU (must be >= 1).
- DIV_LAT, 10, cycles from the start edge to the HI/LO commit for DIV/DIVU (must be >= 1).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- A  in  32  rs operand; dividend / multiplicand; MTHI/MTLO data.
- B  in  32  rt operand; divisor / multiplier.
- MDOp  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- start  in  1  one-cycle request strobe; qualifies MDOp/A/B.
- flush  in  1  exception/interrupt flush; aborts any in-flight operation.
- busy  out  1  1 while an operation is pending.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, pending results=0. Reset mid-operation discards the operation.
- States:
  - IDLE (busy=0) and RUN (busy=1).
  - Down-counter cnt plus pending registers pend_hi/pend_lo, all internal.
- IDLE, start=1, flush=0, MDOp in 0..3:
  - At edge t, compute the result from A/B and latch it into pend_hi/pend_lo.
  - Load cnt = LAT-1 and enter RUN; busy=1 from edge t.
- RUN: cnt decrements each edge.
  - At the edge where cnt==0: HI<=pend_hi, LO<=pend_lo, busy<=0, return to IDLE.
  - Net effect: busy is high for exactly LAT cycles, and new HI/LO are visible in the cycle after busy falls.
- MTHI/MTLO (IDLE, start=1, flush=0):
  - HI<=A (or LO<=A) at that edge.
  - busy stays 0; the other register is unchanged.
- MDOp 6/7 with start=1: no effect.
- start while busy=1: ignored; the pipeline guarantees a stall.
- flush=1:
  - In RUN: return to IDLE next edge, busy<=0, HI/LO unchanged, pending discarded.
  - In IDLE: a simultaneous start is ignored. Flush beats start, including MTHI/MTLO.
- Arithmetic:
  - MULT: {HI,LO} = signed A × signed B, 64-bit.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of A.
  - DIVU: unsigned LO = A/B, HI = A%B.
- Boundary cases:
  - DIVU with B=0: LO=0xFFFFFFFF, HI=A.
  - DIV with B=0: LO = A[31] ? 0x00000001 : 0xFFFFFFFF, HI=A.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
- Operands are sampled only at the start edge. A/B changing during RUN has no effect.
- HI/LO are never partially updated; both are written at the same edge.

Decomposition:
- Package md_pkg holds:
  - MDOp encodings (MD_MULT..MD_MTLO);
  - default latencies MULT_LAT_D=5 and DIV_LAT_D=10;
  - the state enum {MD_IDLE, MD_RUN}.
- Optional sub-module md_calc: purely combinational; (A, B, MDOp) -> {res_hi, res_lo}, including the divide-by-zero and overflow rules.
- md_unit keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset low mid-RUN (2 cycles after DIV start) -> busy=0, HI=LO=0 immediately; no later commit.
- MULT A=0xFFFFFFFE (-2), B=3, start one cycle -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Start re-pulsed with MULT during busy -> ignored; result unchanged.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated one edge after each; busy never asserted.
- MULT start, flush at cycle 3 of RUN -> busy drops next edge, HI/LO keep prior values. Start+flush in the same cycle -> no operation, busy stays 0.
